// File: rtl/fp8_mul_pkg.sv
// rtl/fp8_mul_pkg.sv - shared FP8/FP32 types and response FIFO entry layout
package fp8_mul_pkg;

    localparam int FP8_W    = 8;
    localparam int FP32_W   = 32;
    localparam int RSP_ID_W = 4;

    typedef logic [FP8_W-1:0]  fp8_t;
    typedef logic [FP32_W-1:0] fp32_t;

    // Id field sized for the largest supported requester count (16).
    typedef struct packed {
        logic [RSP_ID_W-1:0] id;
        fp32_t               data;
    } fp8_rsp_t;

endpackage

// File: rtl/fp8_rr_arbiter.sv
// rtl/fp8_rr_arbiter.sv - round-robin arbiter, priority starts after the last grant
module fp8_rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_next;
    logic [PW-1:0] w_idx;
    logic          w_found;

    always_comb begin
        grant   = '0;
        w_next  = r_ptr;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = PW'((int'(r_ptr) + i) % N);
            if (en && !w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_found      = 1'b1;
                w_next       = (w_idx == PW'(N - 1)) ? '0 : w_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= w_next;
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/fp8_mul_scheduler.sv
// rtl/fp8_mul_scheduler.sv - shares one FP8 multiplier among requesters; FP8_MUL_SCHED_PERF_EN adds perf counters
module fp8_mul_scheduler
    import fp8_mul_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int MUL_LATENCY = 1,
    parameter  int RSP_DEPTH   = 4,
    localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*8-1:0] req_a,
    input  logic [NUM_REQ*8-1:0] req_b,
    output logic [7:0]           mul_a,
    output logic [7:0]           mul_b,
    input  logic [31:0]          mul_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_data,
`ifdef FP8_MUL_SCHED_PERF_EN
    output logic [31:0]          perf_issue_cnt,
    output logic [31:0]          perf_stall_cnt,
`endif
    output logic                 busy
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = $clog2(RSP_DEPTH);

    logic [CNT_W-1:0] r_cnt;
    fp8_t             r_mul_a, r_mul_b;
    logic [MUL_LATENCY:0] r_tag_v;
    logic [ID_W-1:0]  r_tag_id [MUL_LATENCY+1];
    fp8_rsp_t         r_fifo [RSP_DEPTH];
    logic [PTR_W:0]   r_wr, r_rd;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_ptr;
    logic [ID_W-1:0]    w_gnt_id;
    logic [PTR_W:0]     w_occ;
    fp8_rsp_t           w_head;
    logic w_credit, w_issue, w_push, w_pop;

    // Registered credit only: a pop in this cycle frees a slot next cycle.
    assign w_credit = (r_cnt < CNT_W'(RSP_DEPTH)) && rstn;

    fp8_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .rstn    (rstn),
        .req     (req_valid),
        .en      (w_credit),
        .advance (w_issue),
        .grant   (w_grant),
        .ptr     (w_ptr)
    );

    always_comb begin
        w_gnt_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) w_gnt_id = ID_W'(i);
        end
    end

    assign req_ready = w_grant;
    assign w_issue   = |(req_valid & w_grant);
    assign w_push    = r_tag_v[MUL_LATENCY];
    assign w_occ     = r_wr - r_rd;
    assign rsp_valid = (r_wr != r_rd);
    assign w_pop     = rsp_valid && rsp_ready;
    assign w_head    = r_fifo[r_rd[PTR_W-1:0]];
    assign rsp_id    = ID_W'(w_head.id);
    assign rsp_data  = w_head.data;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign busy      = (r_cnt != '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt   <= '0;
            r_mul_a <= '0;
            r_mul_b <= '0;
            r_tag_v <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            for (int i = 0; i <= MUL_LATENCY; i++) r_tag_id[i] <= '0;
            for (int i = 0; i < RSP_DEPTH; i++)    r_fifo[i]   <= '0;
        end else begin
            if (w_issue) begin
                r_mul_a <= req_a[8*w_gnt_id +: 8];
                r_mul_b <= req_b[8*w_gnt_id +: 8];
            end
            case ({w_issue, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            // Tag stage MUL_LATENCY lines up with mul_result for the same issue.
            r_tag_v     <= {r_tag_v[MUL_LATENCY-1:0], w_issue};
            r_tag_id[0] <= w_gnt_id;
            for (int i = 1; i <= MUL_LATENCY; i++) r_tag_id[i] <= r_tag_id[i-1];
            if (w_push) begin
                r_fifo[r_wr[PTR_W-1:0]] <= '{id: RSP_ID_W'(r_tag_id[MUL_LATENCY]), data: mul_result};
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
        end
    end

`ifdef FP8_MUL_SCHED_PERF_EN
    logic [31:0] r_perf_issue, r_perf_stall;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_perf_issue <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_issue) r_perf_issue <= r_perf_issue + 1'b1;
            if ((|req_valid) && !(|w_grant)) r_perf_stall <= r_perf_stall + 1'b1;
        end
    end

    assign perf_issue_cnt = r_perf_issue;
    assign perf_stall_cnt = r_perf_stall;
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        w_push |-> (int'(w_occ) < RSP_DEPTH));
    a_ptr_range: assert property (@(posedge clk) disable iff (!rstn)
        int'(w_ptr) < NUM_REQ);

endmodule

// File: tb/tb_fp8_mul_scheduler.sv
// tb/tb_fp8_mul_scheduler.sv - scoreboard bench for fp8_mul_scheduler with a 1-cycle multiplier stand-in
module tb_fp8_mul_scheduler;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [7:0]  mul_a, mul_b;
    logic [31:0] mul_result;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_id;
    logic [31:0] rsp_data;
    logic        busy;
`ifdef FP8_MUL_SCHED_PERF_EN
    logic [31:0] perf_issue_cnt, perf_stall_cnt;
`endif

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
    } ent_t;

    ent_t exp_q[$];
    ent_t got_q[$];
    int   gnt_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    fp8_mul_scheduler #(.NUM_REQ(4), .MUL_LATENCY(1), .RSP_DEPTH(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
`ifdef FP8_MUL_SCHED_PERF_EN
        .perf_issue_cnt (perf_issue_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Data-agnostic stand-in: only the known E4M3 1.0*2.0 pair gets a real product.
    function automatic logic [31:0] fake_mul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h38 && b == 8'h40) return 32'h4000_0000;
        return {a, b, a ^ b, ~a};
    endfunction

    always @(posedge clk) mul_result <= fake_mul(mul_a, mul_b);

    always @(negedge clk) begin
        if (rstn) begin
            for (int k = 0; k < 4; k++) begin
                if (req_valid[k] && req_ready[k]) begin
                    exp_q.push_back('{id: 2'(k), data: fake_mul(req_a[8*k +: 8], req_b[8*k +: 8])});
                    gnt_q.push_back(k);
                end
            end
            if (rsp_valid && rsp_ready) got_q.push_back('{id: rsp_id, data: rsp_data});
        end
    end

    task automatic test_reset();
        ent_t g, e;
        req_valid = 4'hF;
        #2 rstn = 1'b0;
        #2;
        n_total++; if (req_ready !== 4'h0) $display("FAIL reset_req_ready got %h exp 0", req_ready); else n_pass++;
        n_total++; if ({mul_a, mul_b} !== 16'h0) $display("FAIL reset_mul got %h exp 0", {mul_a, mul_b}); else n_pass++;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); else n_pass++;
        n_total++; if (rsp_id !== 2'd0) $display("FAIL reset_rsp_id got %0d exp 0", rsp_id); else n_pass++;
        n_total++; if (rsp_data !== 32'h0) $display("FAIL reset_rsp_data got %h exp 0", rsp_data); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
        req_valid = 4'h0;
        @(posedge clk); @(posedge clk); #1 rstn = 1'b1;
    endtask

    task automatic test_single();
        ent_t g, e;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 4'b0100;
        req_a[23:16] = 8'h38;
        req_b[23:16] = 8'h40;
        @(negedge clk);
        n_total++; if (req_ready !== 4'b0100) $display("FAIL single_grant got %b exp 0100", req_ready); else n_pass++;
        @(posedge clk); #1 req_valid = 4'h0;
        @(negedge clk);
        n_total++; if (mul_a !== 8'h38 || mul_b !== 8'h40) $display("FAIL single_mul_ops got %h/%h exp 38/40", mul_a, mul_b); else n_pass++;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL single_early1 got %b exp 0", rsp_valid); else n_pass++;
        @(negedge clk);
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL single_early2 got %b exp 0", rsp_valid); else n_pass++;
        @(negedge clk);
        n_total++; if (rsp_valid !== 1'b1) $display("FAIL single_rsp_valid got %b exp 1", rsp_valid); else n_pass++;
        n_total++; if (rsp_id !== 2'd2) $display("FAIL single_rsp_id got %0d exp 2", rsp_id); else n_pass++;
        n_total++; if (rsp_data !== 32'h4000_0000) $display("FAIL single_rsp_data got %h exp 40000000", rsp_data); else n_pass++;
        @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL single_busy_after got %b exp 0", busy); else n_pass++;
        n_total++; if (got_q.size() != exp_q.size()) $display("FAIL single_count got %0d exp %0d", got_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_total++; if (g !== e) $display("FAIL single_sb got %h exp %h", g, e); else n_pass++;
        end
        exp_q.delete(); got_q.delete(); gnt_q.delete();
    endtask

    task automatic test_fair_rotation();
        ent_t g, e;
        @(posedge clk); #1 rstn = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        exp_q.delete(); got_q.delete(); gnt_q.delete();
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        for (int i = 0; i < 12; i++) begin
            req_a = $urandom;
            req_b = $urandom;
            @(posedge clk); #1;
        end
        req_valid = 4'h0;
        n_total++; if (gnt_q.size() != 12) $display("FAIL rot_issue_count got %0d exp 12", gnt_q.size()); else n_pass++;
        for (int i = 0; i < gnt_q.size(); i++) begin
            n_total++; if (gnt_q[i] != i % 4) $display("FAIL rot_grant_%0d got %0d exp %0d", i, gnt_q[i], i % 4); else n_pass++;
        end
        repeat (5) @(posedge clk); #1;
        n_total++; if (got_q.size() != exp_q.size()) $display("FAIL rot_count got %0d exp %0d", got_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_total++; if (g !== e) $display("FAIL rot_sb got %h exp %h", g, e); else n_pass++;
        end
        exp_q.delete(); got_q.delete(); gnt_q.delete();
    endtask

    task automatic test_pointer_wrap();
        ent_t g, e;
        req_a = 32'h1122_3344;
        req_b = 32'h5566_7788;
        req_valid = 4'b1001;
        @(negedge clk);
        n_total++; if (req_ready !== 4'b0001) $display("FAIL wrap_first got %b exp 0001", req_ready); else n_pass++;
        @(posedge clk); #1;
        @(negedge clk);
        n_total++; if (req_ready !== 4'b1000) $display("FAIL wrap_second got %b exp 1000", req_ready); else n_pass++;
        @(posedge clk); #1 req_valid = 4'h0;
        repeat (5) @(posedge clk); #1;
        n_total++; if (got_q.size() != 2 || exp_q.size() != 2) $display("FAIL wrap_count got %0d exp %0d", got_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_total++; if (g !== e) $display("FAIL wrap_sb got %h exp %h", g, e); else n_pass++;
        end
        exp_q.delete(); got_q.delete(); gnt_q.delete();
    endtask

    task automatic test_backpressure();
        ent_t g, e;
        @(posedge clk); #1 rstn = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        exp_q.delete(); got_q.delete(); gnt_q.delete();
        rsp_ready = 1'b0;
        req_a = 32'hA1B2_C3D4;
        req_b = 32'h0F1E_2D3C;
        req_valid = 4'hF;
        repeat (13) @(posedge clk);
        @(negedge clk);
        n_total++; if (req_ready !== 4'h0) $display("FAIL bp_ready_low got %b exp 0000", req_ready); else n_pass++;
        n_total++; if (gnt_q.size() != 4) $display("FAIL bp_issue_count got %0d exp 4", gnt_q.size()); else n_pass++;
        @(posedge clk); #1 req_valid = 4'h0;
        @(negedge clk);
`ifdef FP8_MUL_SCHED_PERF_EN
        n_total++; if (perf_issue_cnt !== 32'd4) $display("FAIL perf_issue got %0d exp 4", perf_issue_cnt); else n_pass++;
        n_total++; if (perf_stall_cnt !== 32'd10) $display("FAIL perf_stall got %0d exp 10", perf_stall_cnt); else n_pass++;
`endif
        n_total++; if (busy !== 1'b1) $display("FAIL bp_busy got %b exp 1", busy); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (rsp_valid !== 1'b1 || rsp_id !== exp_q[0].id || rsp_data !== exp_q[0].data)
                $display("FAIL bp_stall_head_%0d got %b/%0d/%h exp 1/%0d/%h", i, rsp_valid, rsp_id, rsp_data, exp_q[0].id, exp_q[0].data);
            else n_pass++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        repeat (6) @(posedge clk); #1;
        req_valid = 4'h0;
        n_total++; if (gnt_q.size() != 9) $display("FAIL bp_resume_count got %0d exp 9", gnt_q.size()); else n_pass++;
        repeat (10) @(posedge clk); #1;
        n_total++; if (got_q.size() != exp_q.size()) $display("FAIL bp_count got %0d exp %0d", got_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_total++; if (g !== e) $display("FAIL bp_sb got %h exp %h", g, e); else n_pass++;
        end
        n_total++; if (busy !== 1'b0) $display("FAIL bp_idle got %b exp 0", busy); else n_pass++;
        exp_q.delete(); got_q.delete(); gnt_q.delete();
    endtask

    task automatic test_reset_mid();
        int seen;
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (busy !== 1'b1) $display("FAIL mid_busy_before got %b exp 1", busy); else n_pass++;
        rstn = 1'b0;
        #1;
        n_total++; if (req_ready !== 4'h0) $display("FAIL mid_req_ready got %b exp 0", req_ready); else n_pass++;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL mid_rsp_valid got %b exp 0", rsp_valid); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL mid_busy got %b exp 0", busy); else n_pass++;
        n_total++; if ({mul_a, mul_b} !== 16'h0) $display("FAIL mid_mul got %h exp 0", {mul_a, mul_b}); else n_pass++;
        n_total++; if (rsp_data !== 32'h0 || rsp_id !== 2'd0) $display("FAIL mid_rsp got %0d/%h exp 0/0", rsp_id, rsp_data); else n_pass++;
        exp_q.delete(); got_q.delete(); gnt_q.delete();
        @(posedge clk); @(posedge clk); #1;
        req_valid = 4'h0;
        rstn = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen++;
        end
        n_total++; if (seen != 0) $display("FAIL mid_no_rsp got %0d exp 0", seen); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fair_rotation();
        test_pointer_wrap();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
